// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 datapath: word/round-key types,
// round count, the key-schedule round constants and the expansion FSM states.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] roundkey_t;

  localparam int NR   = 10;
  localparam int KS_W = 128 * (NR + 1);

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  // Rounds outside 1..10 never reach the datapath, but returning zero keeps the lookup total.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) return RCON[r];
    else return 8'h00;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in and one byte out.
// Used four times for SubWord and reusable by a SubBytes stage.
module aes_sbox (
  input  logic [7:0] plain,
  output logic [7:0] subst
);

  // Row-major table with entry 0 in the top byte, so ~plain selects the slot.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx   = {~plain, 3'b000};
  assign subst = SBOX[idx +: 8];

endmodule

// File: rtl/aes_key_expansion.sv
// Sequential AES-128 key schedule: one round key per cycle into a flat
// 1408-bit register, plus a combinational round-key read port.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [127:0]      key,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [KS_W-1:0]   key_schedule,
  input  logic [3:0]        rd_round,
  output logic [127:0]      rd_key
);

  state_t      state;
  logic [3:0]  rnd;
  roundkey_t   w;

  word_t       w0, w1, w2, w3;
  word_t       rot, sub, temp;
  word_t       n0, n1, n2, n3;
  roundkey_t   next_w;
  logic [10:0] wr_base;
  logic [10:0] rd_base;

  assign w0 = w[127:96];
  assign w1 = w[95:64];
  assign w2 = w[63:32];
  assign w3 = w[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .plain (rot[8*i +: 8]),
      .subst (sub[8*i +: 8])
    );
  end

  assign temp   = sub ^ {rcon_lookup(rnd), 24'h000000};
  assign n0     = w0 ^ temp;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign next_w = {n0, n1, n2, n3};

  assign wr_base = {rnd, 7'b0000000};
  assign rd_base = {rd_round, 7'b0000000};

  // No valid gating here; the consumer is expected to qualify with valid.
  assign rd_key = (rd_round <= 4'(NR)) ? key_schedule[rd_base +: 128] : 128'b0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      rnd          <= 4'd0;
      w            <= '0;
      key_schedule <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w                   <= key;
            key_schedule[127:0] <= key;
            valid               <= 1'b0;
            rnd                 <= 4'd1;
            busy                <= 1'b1;
            state               <= EXPAND;
          end
        end
        EXPAND: begin
          key_schedule[wr_base +: 128] <= next_w;
          w                            <= next_w;
          rnd                          <= rnd + 4'd1;
          if (rnd == 4'(NR)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion using FIPS-197 and all-zero key vectors.
module tb_aes_key_expansion;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           start;
  logic [127:0]   key;
  logic           busy;
  logic           done;
  logic           valid;
  logic [1407:0]  key_schedule;
  logic [3:0]     rd_round;
  logic [127:0]   rd_key;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0]  fips_rk [0:10];
  logic [1407:0] fips_ks;

  aes_key_expansion dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .key          (key),
    .busy         (busy),
    .done         (done),
    .valid        (valid),
    .key_schedule (key_schedule),
    .rd_round     (rd_round),
    .rd_key       (rd_key)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pulses start for one edge; returns 1ns after that edge (E0).
  task automatic start_run(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    start    = 1'b0;
    key      = '0;
    rd_round = 4'd0;
    tick();
    tick();
    Reset = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    n_cmp++;
    if (valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++;
    if (key_schedule !== 1408'b0) begin n_err++; $display("[TB] FAIL reset_schedule not zero, slice0 got=%h", key_schedule[127:0]); end
    n_cmp++;
    if (rd_key !== 128'b0) begin n_err++; $display("[TB] FAIL reset_rd_key got=%h exp=0", rd_key); end
  endtask

  task automatic test_fips();
    start_run(FIPS_KEY);
    n_cmp++;
    if (busy !== 1'b1 || valid !== 1'b0) begin n_err++; $display("[TB] FAIL fips_start busy=%b valid=%b exp busy=1 valid=0", busy, valid); end
    for (int k = 1; k < 10; k++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL fips_busy_cycle%0d busy=%b done=%b exp busy=1 done=0", k, busy, done);
      end
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL fips_done done=%b busy=%b valid=%b exp 1/0/1", done, busy, valid);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || valid !== 1'b1) begin n_err++; $display("[TB] FAIL fips_done_pulse done=%b valid=%b exp 0/1", done, valid); end
    n_cmp++;
    if (key_schedule[127:0] !== FIPS_KEY) begin n_err++; $display("[TB] FAIL fips_round0 got=%h exp=%h", key_schedule[127:0], FIPS_KEY); end
    n_cmp++;
    if (key_schedule[255:128] !== fips_rk[1]) begin n_err++; $display("[TB] FAIL fips_round1 got=%h exp=%h", key_schedule[255:128], fips_rk[1]); end
    n_cmp++;
    if (key_schedule[1407:1280] !== fips_rk[10]) begin n_err++; $display("[TB] FAIL fips_round10 got=%h exp=%h", key_schedule[1407:1280], fips_rk[10]); end
    n_cmp++;
    if (key_schedule !== fips_ks) begin n_err++; $display("[TB] FAIL fips_schedule full schedule differs"); end
  endtask

  task automatic test_read_port();
    for (int r = 0; r < 16; r++) begin
      rd_round = 4'(r);
      #1;
      n_cmp++;
      if (r <= 10) begin
        if (rd_key !== fips_rk[r]) begin n_err++; $display("[TB] FAIL rd_port_%0d got=%h exp=%h", r, rd_key, fips_rk[r]); end
      end else begin
        if (rd_key !== 128'b0) begin n_err++; $display("[TB] FAIL rd_port_%0d got=%h exp=0", r, rd_key); end
      end
    end
    rd_round = 4'd0;
  endtask

  task automatic test_zero_key();
    start_run(ZERO_KEY);
    repeat (10) tick();
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b1) begin n_err++; $display("[TB] FAIL zero_done done=%b valid=%b exp 1/1", done, valid); end
    n_cmp++;
    if (key_schedule[127:0] !== ZERO_KEY) begin n_err++; $display("[TB] FAIL zero_round0 got=%h exp=0", key_schedule[127:0]); end
    n_cmp++;
    if (key_schedule[255:128] !== ZERO_R1) begin n_err++; $display("[TB] FAIL zero_round1 got=%h exp=%h", key_schedule[255:128], ZERO_R1); end
    n_cmp++;
    if (key_schedule[1407:1280] !== ZERO_R10) begin n_err++; $display("[TB] FAIL zero_round10 got=%h exp=%h", key_schedule[1407:1280], ZERO_R10); end
    tick();
  endtask

  task automatic test_start_ignored();
    start_run(FIPS_KEY);
    repeat (3) tick();
    key   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL ignore_busy got=%b exp=1", busy); end
    repeat (5) tick();
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("[TB] FAIL ignore_early_done got=%b exp=0", done); end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("[TB] FAIL ignore_done_timing got=%b exp=1", done); end
    n_cmp++;
    if (key_schedule !== fips_ks) begin n_err++; $display("[TB] FAIL ignore_schedule round10 got=%h exp=%h", key_schedule[1407:1280], fips_rk[10]); end
    tick();
  endtask

  task automatic test_reset_mid();
    start_run(FIPS_KEY);
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midreset_flags busy=%b valid=%b done=%b exp 0/0/0", busy, valid, done);
    end
    n_cmp++;
    if (key_schedule !== 1408'b0) begin n_err++; $display("[TB] FAIL midreset_schedule slice0 got=%h exp=0", key_schedule[127:0]); end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_idle busy=%b exp=0", busy); end
    start_run(FIPS_KEY);
    repeat (10) tick();
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("[TB] FAIL midreset_rerun_done got=%b exp=1", done); end
    n_cmp++;
    if (key_schedule !== fips_ks) begin n_err++; $display("[TB] FAIL midreset_rerun_schedule round10 got=%h exp=%h", key_schedule[1407:1280], fips_rk[10]); end
  endtask

  // Entered 1ns after the done edge of the previous run.
  task automatic test_back_to_back();
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_precondition done=%b exp=1", done); end
    start_run(ZERO_KEY);
    n_cmp++;
    if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_accept valid=%b busy=%b done=%b exp 0/1/0", valid, busy, done);
    end
    n_cmp++;
    if (key_schedule[1407:1280] !== fips_rk[10]) begin n_err++; $display("[TB] FAIL b2b_stale_round10 got=%h exp=%h", key_schedule[1407:1280], fips_rk[10]); end
    repeat (10) tick();
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_done done=%b valid=%b exp 1/1", done, valid); end
    n_cmp++;
    if (key_schedule[255:128] !== ZERO_R1) begin n_err++; $display("[TB] FAIL b2b_round1 got=%h exp=%h", key_schedule[255:128], ZERO_R1); end
    n_cmp++;
    if (key_schedule[1407:1280] !== ZERO_R10) begin n_err++; $display("[TB] FAIL b2b_round10 got=%h exp=%h", key_schedule[1407:1280], ZERO_R10); end
  endtask

  initial begin
    fips_rk[0]  = FIPS_KEY;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i <= 10; i++) fips_ks[128*i +: 128] = fips_rk[i];

    test_reset();
    test_fips();
    test_read_port();
    test_zero_key();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
